// File: rtl/catc_enable_divider.sv
// Divides the master tick stream into two phase-locked enables (EnA, EnB) with an
// aligned halt that only freezes on a common frame boundary, plus a consumed-tick counter.
module catc_enable_divider #(
    parameter int DIV_A   = 12,
    parameter int DIV_B   = 4,
    parameter int PHASE_B = 0,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          TickIn,
    input  logic          HaltReq,
    input  logic          ResyncReq,
    output logic          EnA,
    output logic          EnB,
    output logic [CW-1:0] PhaseA,
    output logic [CW-1:0] PhaseB,
    output logic          Halted,
    output logic [31:0]   TickCount
);

    if (DIV_A < 1 || longint'(DIV_A) > (longint'(1) << CW) ||
        DIV_B < 1 || longint'(DIV_B) > (longint'(1) << CW) ||
        PHASE_B < 0 || PHASE_B >= DIV_B) begin : g_bad_params
        $error("catc_enable_divider: illegal DIV_A/DIV_B/PHASE_B for CW");
    end

    localparam logic [CW-1:0] LAST_A = CW'(DIV_A - 1);
    localparam logic [CW-1:0] LAST_B = CW'(DIV_B - 1);
    localparam logic [CW-1:0] INIT_B = CW'(PHASE_B);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] cnt_a_nxt;
    logic [CW-1:0] cnt_b_nxt;
    logic          consumed;
    logic          aligned_nxt;
    logic          en_a_nxt;
    logic          en_b_nxt;

    always_comb begin
        consumed  = TickIn && (state != S_HALTED) && !ResyncReq;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        if (ResyncReq) begin
            cnt_a_nxt = '0;
            cnt_b_nxt = INIT_B;
        end else if (consumed) begin
            cnt_a_nxt = (cnt_a == LAST_A) ? '0 : cnt_a + 1'b1;
            cnt_b_nxt = (cnt_b == LAST_B) ? '0 : cnt_b + 1'b1;
        end
        en_a_nxt    = consumed && (cnt_a_nxt == '0);
        en_b_nxt    = consumed && (cnt_b_nxt == '0);
        // Alignment is judged on the post-update counters so a wrapping tick can halt.
        aligned_nxt = (cnt_a_nxt == '0) && (cnt_b_nxt == INIT_B);

        state_nxt = state;
        case (state)
            S_RUN: begin
                if (HaltReq) begin
                    state_nxt = aligned_nxt ? S_HALTED : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!HaltReq) begin
                    state_nxt = S_RUN;
                end else if (aligned_nxt) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!HaltReq) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_RUN;
            cnt_a     <= '0;
            cnt_b     <= INIT_B;
            EnA       <= 1'b0;
            EnB       <= 1'b0;
            Halted    <= 1'b0;
            TickCount <= '0;
        end else begin
            state  <= state_nxt;
            cnt_a  <= cnt_a_nxt;
            cnt_b  <= cnt_b_nxt;
            EnA    <= en_a_nxt;
            EnB    <= en_b_nxt;
            Halted <= (state_nxt == S_HALTED);
            if (consumed) begin
                TickCount <= TickCount + 32'd1;
            end
        end
    end

    assign PhaseA = cnt_a;
    assign PhaseB = cnt_b;

endmodule

// File: tb/tb_catc_enable_divider.sv
// Bench for catc_enable_divider: default instance plus a DIV_A=DIV_B=4, PHASE_B=2 instance,
// both compared every cycle against a tick-count reference model through a scoreboard queue.
module tb_catc_enable_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick;
    logic halt;
    logic resync;

    logic [1:0]  en_a;
    logic [1:0]  en_b;
    logic [1:0]  hlt;
    logic [7:0]  pha [2];
    logic [7:0]  phb [2];
    logic [31:0] tcnt [2];

    catc_enable_divider u_dut0 (
        .clk(clk), .Reset(rst), .TickIn(tick), .HaltReq(halt), .ResyncReq(resync),
        .EnA(en_a[0]), .EnB(en_b[0]), .PhaseA(pha[0]), .PhaseB(phb[0]),
        .Halted(hlt[0]), .TickCount(tcnt[0])
    );

    catc_enable_divider #(.DIV_A(4), .DIV_B(4), .PHASE_B(2), .CW(8)) u_dut1 (
        .clk(clk), .Reset(rst), .TickIn(tick), .HaltReq(halt), .ResyncReq(resync),
        .EnA(en_a[1]), .EnB(en_b[1]), .PhaseA(pha[1]), .PhaseB(phb[1]),
        .Halted(hlt[1]), .TickCount(tcnt[1])
    );

    typedef struct packed {
        logic        ena;
        logic        enb;
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic        halted;
        logic [31:0] tc;
    } obs_t;

    typedef struct {
        int   cyc;
        int   inst;
        obs_t exp;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int da [2] = '{12, 4};
    int db [2] = '{4, 4};
    int pb [2] = '{0, 2};

    // Reference state: ticks consumed since the last reset/resync, total count, halted flag.
    int          n [2];
    logic [31:0] m_tc [2];
    bit          m_halted [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_step(input int i, input bit r, input bit t,
                                       input bit h, input bit s, output obs_t o);
        bit ca;
        ca = 1'b0;
        o  = '0;
        if (r) begin
            n[i]        = 0;
            m_tc[i]     = 0;
            m_halted[i] = 1'b0;
        end else begin
            ca = t && !m_halted[i] && !s;
            if (s) begin
                n[i] = 0;
            end else if (ca) begin
                n[i]    = n[i] + 1;
                m_tc[i] = m_tc[i] + 1;
            end
            o.ena = ca && (n[i] % da[i] == 0);
            o.enb = ca && ((pb[i] + n[i]) % db[i] == 0);
            if (m_halted[i])
                m_halted[i] = h;
            else
                m_halted[i] = h && (n[i] % da[i] == 0) && (n[i] % db[i] == 0);
        end
        o.pa     = 8'(n[i] % da[i]);
        o.pb     = 8'((pb[i] + n[i]) % db[i]);
        o.halted = m_halted[i];
        o.tc     = m_tc[i];
    endfunction

    task automatic drive(input bit r, input bit t, input bit h, input bit s);
        obs_t o;
        exp_t e;
        rst    = r;
        tick   = t;
        halt   = h;
        resync = s;
        for (int i = 0; i < 2; i++) begin
            model_step(i, r, t, h, s, o);
            e.cyc  = cyc + 1;
            e.inst = i;
            e.exp  = o;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                a = {en_a[e.inst], en_b[e.inst], pha[e.inst], phb[e.inst],
                     hlt[e.inst], tcnt[e.inst]};
                checks++;
                if (e.cyc != cyc || a !== e.exp) begin
                    errors++;
                    $display("FAIL outputs inst%0d cyc %0d (due %0d): got en=%b%b pa=%0d pb=%0d halted=%b tc=%0d, expected en=%b%b pa=%0d pb=%0d halted=%b tc=%0d",
                             e.inst, cyc, e.cyc, a.ena, a.enb, a.pa, a.pb, a.halted, a.tc,
                             e.exp.ena, e.exp.enb, e.exp.pa, e.exp.pb, e.exp.halted, e.exp.tc);
                end
            end
        end
    end

    initial begin : stimulus
        bit h;
        rst = 1'b1; tick = 1'b0; halt = 1'b0; resync = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        // Continuous ticks
        repeat (24) drive(0, 1, 0, 0);
        // Tick every third cycle
        drive(1, 0, 0, 0);
        for (int k = 0; k < 108; k++) drive(0, (k % 3) == 0, 0, 0);
        // Halt raised after 5 ticks, held through drain and freeze, then released
        drive(1, 0, 0, 0);
        repeat (5) drive(0, 1, 0, 0);
        repeat (17) drive(0, 1, 1, 0);
        repeat (12) drive(0, 1, 0, 0);
        // Halt withdrawn during drain
        drive(1, 0, 0, 0);
        repeat (5) drive(0, 1, 0, 0);
        repeat (3) drive(0, 1, 1, 0);
        repeat (10) drive(0, 1, 0, 0);
        // Resync on tick 7
        drive(1, 0, 0, 0);
        repeat (6) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        repeat (14) drive(0, 1, 0, 0);
        // Halt requested straight out of reset, then resync while halted
        drive(1, 0, 1, 0);
        drive(0, 0, 1, 0);
        repeat (6) drive(0, 1, 1, 0);
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 0);
        repeat (8) drive(0, 1, 0, 0);
        // Randomized traffic with held halt levels
        h = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) h = ~h;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, h,
                  $urandom_range(0, 29) == 0);
        end
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/catc_enable_divider.md
Name: catc_enable_divider

Overview:
- Consumes the single-cycle master tick stream (ClkEnOut) from the clock-enable timing controller and derives two phase-locked, lower-rate enables, e.g. CPU at /12 and PPU at /4 of master.
- Provides an aligned halt (freeze only on a common frame boundary), a resync strobe, and a consumed-tick counter for lag monitoring against the reference tick count.

Parameters:
- DIV_A, 12, divide ratio for EnA (1..2**CW).
- DIV_B, 4, divide ratio for EnB (1..2**CW).
- PHASE_B, 0, reset/resync value of counter B (0..DIV_B-1); skews EnB relative to EnA.
- CW, 8, counter width.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- TickIn  in  1  master tick enable from the timing controller; one tick per high cycle.
- HaltReq  in  1  level; request aligned freeze.
- ResyncReq  in  1  pulse; force counters to reset values.
- EnA  out  1  one-cycle enable, divided by DIV_A.
- EnB  out  1  one-cycle enable, divided by DIV_B.
- PhaseA  out  CW  current value of counter A.
- PhaseB  out  CW  current value of counter B.
- Halted  out  1  high while in HALTED.
- TickCount  out  32  number of ticks consumed.

Behaviour:
- Elaboration error if DIV_A or DIV_B is 0 or exceeds 2**CW, or if PHASE_B >= DIV_B.
- Reset (priority over everything):
  - cntA=0, cntB=PHASE_B, state=RUN.
  - EnA=EnB=0, Halted=0, TickCount=0.
- Consumed tick = TickIn=1 while state is RUN or DRAIN and ResyncReq=0.
- On a consumed tick:
  - cntA: cntA==DIV_A-1 ? 0 : cntA+1. cntB likewise with DIV_B.
  - TickCount += 1, wraps modulo 2**32.
- EnA and EnB are registered with latency 1:
  - EnA=1 in the cycle after a consumed tick that moved cntA to 0; otherwise 0. EnB likewise, when cntB moves to 0.
  - DIV=1: enable high the cycle after every consumed tick.
  - Never high more than one cycle per tick; both may be high in the same cycle.
- PhaseA/PhaseB show the registered counters, i.e. post-update values one cycle after the tick.
- Aligned means the post-update counters satisfy cntA==0 and cntB==PHASE_B. Aligned recurs every lcm(DIV_A,DIV_B) ticks; 12 for the defaults.
- State machine: RUN, DRAIN, HALTED.
  - RUN, HaltReq=0: stay RUN.
  - RUN, HaltReq=1, aligned after this cycle: go to HALTED.
  - RUN, HaltReq=1, not aligned: go to DRAIN.
  - DRAIN, HaltReq=0: return to RUN; no halt occurs.
  - DRAIN, HaltReq=1: keep consuming ticks; go to HALTED at the end of the first cycle that is aligned after update. That final tick's enables are still emitted.
  - HALTED: TickIn is ignored; counters, TickCount and enables are frozen (enables 0).
  - HALTED, HaltReq=0: go to RUN next cycle. The first tick is consumed in the cycle after Halted falls.
- Halted is registered and equals (state==HALTED).
- ResyncReq=1, any state:
  - Counters load their reset values next cycle.
  - That cycle's TickIn is dropped, not counted, and no enables result.
  - State is otherwise unchanged, except that RUN/DRAIN with HaltReq=1 goes to HALTED, because the block is now aligned.
- Simultaneous TickIn, HaltReq and an aligning wrap: the tick is consumed, its enables are emitted, and the block then enters HALTED.
- Reset during DRAIN or HALTED returns to RUN with Halted=0 next cycle, regardless of HaltReq. If HaltReq is still high, the normal RUN evaluation applies from the following cycle.

Test Plan:
- Defaults, TickIn=1 continuously for 24 cycles after reset: EnA high in cycles 12 and 24; EnB high in cycles 4, 8, 12, 16, 20, 24; TickCount=24.
- TickIn high every 3rd cycle for 36 ticks: EnA pulses exactly 3 times, each one cycle wide, 36 clk apart; TickCount=36.
- After 5 ticks, raise HaltReq and keep TickIn=1:
  - DRAIN consumes 7 more ticks; Halted rises after tick 12; EnA/EnB fire for tick 12.
  - 10 further ticks: TickCount stays 12.
  - Drop HaltReq: counting resumes.
- HaltReq raised at tick 5, dropped at tick 8: no Halted pulse; EnA still at tick 12.
- ResyncReq at tick 7 with TickIn=1: that tick is dropped; PhaseA=0 and PhaseB=PHASE_B next cycle; next EnA after 12 more ticks; TickCount=6.
- PHASE_B=2, DIV_A=DIV_B=4: EnB leads EnA by 2 ticks. With HaltReq asserted from reset, Halted=1 after 1 cycle and no enables occur.
